// File: rtl/mult_arb_pkg.sv
// Shared constants for the multiplier arbiter: FSM state encodings, counter width,
// and the reset value of the last-served pointer.
package mult_arb_pkg;

  localparam int CNT_W = 4;

  typedef logic [1:0] state_t;
  typedef logic [1:0] req_vec_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // "last served = 1" so requester 0 takes the first tie after reset
  localparam logic PTR_RST = 1'b1;

endpackage

// File: rtl/mult_arb_pick.sv
// Combinational winner select for the multiplier arbiter, one-hot output.
// Build switch MULT_ARB_RR_EN: defined = round-robin on ties, undefined = requester 0 priority.
module mult_arb_pick
  import mult_arb_pkg::*;
(
  input  logic     req0_i,
  input  logic     req1_i,
`ifdef MULT_ARB_RR_EN
  input  logic     last_i,
`endif
  output req_vec_t win_o
);

  always_comb begin
    win_o = 2'b00;
    if (req0_i && req1_i) begin
`ifdef MULT_ARB_RR_EN
      win_o = last_i ? 2'b01 : 2'b10;
`else
      win_o = 2'b01;
`endif
    end else if (req0_i) begin
      win_o = 2'b01;
    end else if (req1_i) begin
      win_o = 2'b10;
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Two-port arbiter and sequencer for the shared combinational multiplier.
// Build switch MULT_ARB_RR_EN selects round-robin tie breaking (see mult_arb_pick).
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             REQ0,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] B0,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B1,
  output logic             GNT0,
  output logic             GNT1,
  output logic             DONE0,
  output logic             DONE1,
  output logic [WIDTH-1:0] RESULT,
  output logic             BUSY,
  output logic [WIDTH-1:0] MULT_A,
  output logic [WIDTH-1:0] MULT_B,
  input  logic [WIDTH-1:0] MULT_OUT
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mult_a_q, mult_a_d;
  logic [WIDTH-1:0] mult_b_q, mult_b_d;
  logic [WIDTH-1:0] result_q, result_d;
  req_vec_t         gnt_q, gnt_d;
  req_vec_t         done_q, done_d;
  logic             busy_q, busy_d;
  req_vec_t         win;
`ifdef MULT_ARB_RR_EN
  logic             ptr_q, ptr_d;
`endif

  mult_arb_pick u_pick (
    .req0_i (REQ0),
    .req1_i (REQ1),
`ifdef MULT_ARB_RR_EN
    .last_i (ptr_q),
`endif
    .win_o  (win)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mult_a_d = mult_a_q;
    mult_b_d = mult_b_q;
    result_d = result_q;
    gnt_d    = gnt_q;
    done_d   = done_q;
`ifdef MULT_ARB_RR_EN
    ptr_d    = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win != 2'b00) begin
          mult_a_d = win[1] ? A1 : A0;
          mult_b_d = win[1] ? B1 : B0;
          gnt_d    = win;
          cnt_d    = CNT_LOAD;
          state_d  = ST_WAIT;
`ifdef MULT_ARB_RR_EN
          ptr_d    = win[1];
`endif
        end
      end
      ST_WAIT: begin
        // Capture only once the multiplier has had the full settle window
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          result_d = MULT_OUT;
          done_d   = gnt_q;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        done_d  = 2'b00;
        gnt_d   = 2'b00;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mult_a_q <= '0;
      mult_b_q <= '0;
      result_q <= '0;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      busy_q   <= 1'b0;
`ifdef MULT_ARB_RR_EN
      ptr_q    <= PTR_RST;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mult_a_q <= mult_a_d;
      mult_b_q <= mult_b_d;
      result_q <= result_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
`ifdef MULT_ARB_RR_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

  assign GNT0   = gnt_q[0];
  assign GNT1   = gnt_q[1];
  assign DONE0  = done_q[0];
  assign DONE1  = done_q[1];
  assign RESULT = result_q;
  assign BUSY   = busy_q;
  assign MULT_A = mult_a_q;
  assign MULT_B = mult_b_q;

endmodule
